quantum_rr_scheduler: RTL and testbench



---
 rtl/arb_sched_pkg.sv | 19 +
 rtl/quantum_rr_scheduler_rr_pick.sv | 32 +++
 rtl/quantum_rr_scheduler.sv | 105 ++++++++++
 tb/tb_quantum_rr_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_sched_pkg.sv
// Shared types and helpers for the quantum round-robin scheduler and its picker.
package arb_sched_pkg;

  localparam int DEF_NUM_REQS = 2;
  localparam int DEF_QWID     = 2;
  // Widest one-hot the helper can build; callers truncate to their own width.
  localparam int OH_MAXW      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SERVE = 2'd2
  } state_t;

  function automatic logic [OH_MAXW-1:0] onehot(input int unsigned idx);
    return OH_MAXW'(1) << idx;
  endfunction

endpackage

// File: rtl/quantum_rr_scheduler_rr_pick.sv
// Combinational rotating-priority picker: first set bit of i_elig at or after
// i_ptr, wrapping modulo N. Reusable by any arbiter needing fair selection.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate so bit 0 corresponds to the requester at i_ptr.
  assign w_dbl = {i_elig, i_elig} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Scan from the far end so the nearest eligible requester wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        o_idx   = IW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/quantum_rr_scheduler.sv
// Quantum-weighted round-robin scheduler: the owner may pop up to its latched
// quantum consecutively, then ownership rotates via a one-cycle ARB state.
module quantum_rr_scheduler
  import arb_sched_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  parameter int QWID     = DEF_QWID,
  parameter int IDXW     = $clog2(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS-1:0]      empty,
  input  logic [NUM_REQS*QWID-1:0] quantums,
  output logic [NUM_REQS-1:0]      pop,
  output logic [IDXW-1:0]          grant_idx,
  output logic                     busy,
  output logic [QWID-1:0]          credit
);

  state_t                          r_state, w_next;
  logic [IDXW-1:0]                 r_ptr, r_owner;
  logic [QWID-1:0]                 r_credit;
  logic [NUM_REQS-1:0][QWID-1:0]   r_qreg;

  logic [NUM_REQS-1:0]             w_elig;
  logic                            w_found;
  logic [IDXW-1:0]                 w_pick;
  logic                            w_own_ok;
  logic                            w_leave;
  logic [IDXW-1:0]                 w_ptr_nxt;

  // A requester with quantum 0 is never eligible, so it is never served.
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_elig
    assign w_elig[g] = reqs[g] & ~empty[g] & (r_qreg[g] != '0);
  end

  rr_pick #(.N(NUM_REQS), .IW(IDXW)) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Owner can pop only while it still requests and its FIFO has data.
  assign w_own_ok  = reqs[r_owner] & ~empty[r_owner];
  assign w_leave   = ~w_own_ok | (r_credit == QWID'(1));
  assign w_ptr_nxt = (r_owner == IDXW'(NUM_REQS - 1)) ? '0 : r_owner + IDXW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state: ARB is always at least one cycle; SERVE exits on last credit or stall.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)   w_next = ARB;
      ARB:     if (w_found) w_next = SERVE;
      SERVE:   if (w_leave) w_next = ARB;
      default:              w_next = IDLE;
    endcase
  end

  // Outputs: pop is gated so an empty FIFO is never popped.
  always_comb begin
    pop  = '0;
    busy = (r_state == SERVE);
    if (r_state == SERVE && w_own_ok) pop = NUM_REQS'(onehot(32'(r_owner)));
  end

  assign grant_idx = r_owner;
  assign credit    = r_credit;

  // Datapath: latch quantums once, load credit on grant, burn it down on pops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_credit <= '0;
      r_qreg   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) r_qreg <= quantums;
        ARB: if (w_found) begin
          r_owner  <= w_pick;
          r_credit <= r_qreg[w_pick];
        end
        SERVE: begin
          if (w_leave) begin
            r_credit <= '0;
            r_ptr    <= w_ptr_nxt;
          end else begin
            r_credit <= r_credit - QWID'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_rr_scheduler.sv
// Bench for quantum_rr_scheduler: two instances (2 and 3 requesters), directed
// pattern tables plus random traffic against a turn-based reference model.
module tb_quantum_rr_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start0;
  logic [1:0] reqs0, empty0;
  logic [3:0] q0;
  logic [1:0] pop0;
  logic [0:0] gi0;
  logic       busy0;
  logic [1:0] cr0;

  logic       start1;
  logic [2:0] reqs1, empty1;
  logic [5:0] q1;
  logic [2:0] pop1;
  logic [1:0] gi1;
  logic       busy1;
  logic [1:0] cr1;

  quantum_rr_scheduler #(.NUM_REQS(2), .QWID(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .reqs(reqs0), .empty(empty0),
    .quantums(q0), .pop(pop0), .grant_idx(gi0), .busy(busy0), .credit(cr0)
  );

  quantum_rr_scheduler #(.NUM_REQS(3), .QWID(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .reqs(reqs1), .empty(empty1),
    .quantums(q1), .pop(pop1), .grant_idx(gi1), .busy(busy1), .credit(cr1)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: 0 = waiting for start, 1 = choosing next turn, 2 = in a turn.
  int m_mode[2], m_ptr[2], m_owner[2], m_left[2];
  int m_q[2][3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int can_pop(input int k, input int rq, input int em);
    int o;
    o = m_owner[k];
    return (((rq >> o) & 1) == 1 && ((em >> o) & 1) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_pop(input int k, input int rq, input int em);
    if (m_mode[k] == 2 && can_pop(k, rq, em) == 1) return 1 << m_owner[k];
    return 0;
  endfunction

  task automatic model_step(input int k, input int n, input int rq, input int em,
                            input int st, input int qv, input int rs);
    if (rs == 0) begin
      m_mode[k] = 0; m_ptr[k] = 0; m_owner[k] = 0; m_left[k] = 0;
      for (int i = 0; i < 3; i++) m_q[k][i] = 0;
      return;
    end
    case (m_mode[k])
      0: if (st != 0) begin
        for (int i = 0; i < n; i++) m_q[k][i] = (qv >> (2 * i)) & 3;
        m_mode[k] = 1;
      end
      1: for (int j = 0; j < n; j++) begin
        automatic int i = (m_ptr[k] + j) % n;
        if (((rq >> i) & 1) == 1 && ((em >> i) & 1) == 0 && m_q[k][i] != 0) begin
          m_owner[k] = i;
          m_left[k]  = m_q[k][i];
          m_mode[k]  = 2;
          break;
        end
      end
      default: begin
        automatic int ok = can_pop(k, rq, em);
        if (ok == 1) m_left[k] = m_left[k] - 1;
        if (ok == 0 || m_left[k] == 0) begin
          m_ptr[k]  = (m_owner[k] + 1) % n;
          m_left[k] = 0;
          m_mode[k] = 1;
        end
      end
    endcase
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    chk("pop0",  int'(pop0),  exp_pop(0, int'(reqs0), int'(empty0)));
    chk("busy0", int'(busy0), (m_mode[0] == 2) ? 1 : 0);
    chk("gidx0", int'(gi0),   m_owner[0]);
    chk("cred0", int'(cr0),   m_left[0]);
    chk("pop1",  int'(pop1),  exp_pop(1, int'(reqs1), int'(empty1)));
    chk("busy1", int'(busy1), (m_mode[1] == 2) ? 1 : 0);
    chk("gidx1", int'(gi1),   m_owner[1]);
    chk("cred1", int'(cr1),   m_left[1]);
    model_step(0, 2, int'(reqs0), int'(empty0), int'(start0), int'(q0), int'(rst));
    model_step(1, 3, int'(reqs1), int'(empty1), int'(start1), int'(q1), int'(rst));
    @(posedge clk);
    @(negedge clk);
  endtask

  int pat0[12]  = '{0, 0, 1, 1, 1, 0, 2, 2, 0, 1, 1, 1};
  int cpat0[12] = '{0, 0, 3, 2, 1, 0, 2, 1, 0, 3, 2, 1};
  int pat1[12]  = '{0, 0, 1, 0, 2, 0, 4, 0, 1, 0, 2, 0};
  int gpat1[12] = '{0, 0, 0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
  int pat4[10]  = '{0, 2, 2, 0, 2, 2, 0, 2, 2, 0};

  initial begin
    start0 = 1'b0; reqs0 = 2'b11;  empty0 = '0; q0 = '0;
    start1 = 1'b0; reqs1 = 3'b111; empty1 = '0; q1 = '0;
    rst = 1'b0;
    model_step(0, 2, 0, 0, 0, 0, 0);
    model_step(1, 3, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset held low with requests pending: nothing moves.
    repeat (3) begin
      #1;
      chk("rst_pop",  int'(pop0),  0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_cred", int'(cr0),   0);
      cycle();
    end

    // Quantum pattern on both instances; a restart during SERVE is ignored.
    rst = 1'b1;
    start0 = 1'b1; q0 = 4'b1011;
    start1 = 1'b1; q1 = 6'b010101;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin start0 = 1'b0; start1 = 1'b0; end
      if (i == 3) begin start0 = 1'b1; q0 = 4'b0101; end
      if (i == 4) start0 = 1'b0;
      #1;
      chk("pat_pop0",  int'(pop0), pat0[i]);
      chk("pat_cred0", int'(cr0),  cpat0[i]);
      chk("pat_pop1",  int'(pop1), pat1[i]);
      chk("pat_gidx1", int'(gi1),  gpat1[i]);
      cycle();
    end

    // Owner's FIFO empties mid-turn: pop drops at once, turn passes on.
    rst = 1'b0; cycle();
    rst = 1'b1; start0 = 1'b1; q0 = 4'b1011;
    cycle();
    start0 = 1'b0;
    cycle();
    #1; chk("emp_first_pop", int'(pop0), 1);
    cycle();
    empty0 = 2'b01;
    #1;
    chk("emp_pop",  int'(pop0),  0);
    chk("emp_cred", int'(cr0),   2);
    chk("emp_busy", int'(busy0), 1);
    cycle();
    #1;
    chk("emp_arb_busy", int'(busy0), 0);
    chk("emp_arb_pop",  int'(pop0),  0);
    cycle();
    #1;
    chk("emp_next_pop", int'(pop0), 2);
    chk("emp_next_gi",  int'(gi0),  1);
    cycle();

    // Reset in the middle of a turn: idle next cycle with quantums forgotten.
    rst = 1'b0; cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_pop",  int'(pop0),  0);
    chk("mid_rst_busy", int'(busy0), 0);
    cycle();
    cycle();
    empty0 = '0;

    // Quantum 0 on requester 0: only requester 1 ever served, bursts of 2.
    start0 = 1'b1; q0 = 4'b1000;
    cycle();
    start0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("q0_pop", int'(pop0), pat4[i]);
      cycle();
    end

    // Random traffic, starts and occasional resets against the model.
    for (int i = 0; i < 800; i++) begin
      reqs0  = 2'($urandom | $urandom);
      empty0 = 2'($urandom & $urandom);
      start0 = ($urandom_range(0, 7) == 0);
      q0     = 4'($urandom);
      reqs1  = 3'($urandom | $urandom);
      empty1 = 3'($urandom & $urandom);
      start1 = ($urandom_range(0, 7) == 0);
      q1     = 6'($urandom);
      rst    = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
